sdram_port_arb: RTL and testbench

Three-client arbiter that shares one toggle-handshake port of the dual-port SDRAM controller (port1: req toggles to start, ack echoes req on completion).
- Client 0 is the high-priority video fetcher.
- Clients 1 and 2 (CPU, DMA/tape loader) share the remaining bandwidth round-robin.
- A burst limit stops client 0 from starving clients 1 and 2.
- Each client sees the same toggle req/ack protocol the controller exposes, so any client can be wired directly to the controller without changes.

---
 rtl/sdram_port_arb.sv | 145 ++++++++++++++
 tb/tb_sdram_port_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arb.sv
// Three-client arbiter onto one toggle req/ack SDRAM port: client 0 has priority
// up to C0_BURST back-to-back grants while 1/2 wait, clients 1 and 2 alternate.
module sdram_port_arb #(
  parameter int AW       = 23,
  parameter int C0_BURST = 4
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          c0_req,
  output logic          c0_ack,
  input  logic          c0_we,
  input  logic [AW:1]   c0_a,
  input  logic [1:0]    c0_ds,
  input  logic [15:0]   c0_d,
  output logic [15:0]   c0_q,
  input  logic          c1_req,
  output logic          c1_ack,
  input  logic          c1_we,
  input  logic [AW:1]   c1_a,
  input  logic [1:0]    c1_ds,
  input  logic [15:0]   c1_d,
  output logic [15:0]   c1_q,
  input  logic          c2_req,
  output logic          c2_ack,
  input  logic          c2_we,
  input  logic [AW:1]   c2_a,
  input  logic [1:0]    c2_ds,
  input  logic [15:0]   c2_d,
  output logic [15:0]   c2_q,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW:1]   mem_a,
  output logic [1:0]    mem_ds,
  output logic [15:0]   mem_d,
  input  logic [15:0]   mem_q,
  output logic          busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] BURST = 4'(C0_BURST);

  state_t      state, state_nxt;
  logic [2:0]  req, ack, pend;
  logic [3:0]  c0_run;
  logic        rr;          // 0: client 1 is next in line, 1: client 2
  logic [1:0]  gnt, win;
  logic        gnt_req;
  logic        grant, done, p1, c0_ok, port_idle;
  logic        sel_req, sel_we;
  logic [AW:1] sel_a;
  logic [1:0]  sel_ds;
  logic [15:0] sel_d;

  assign req       = {c2_req, c1_req, c0_req};
  assign pend      = req ^ ack;
  assign {c2_ack, c1_ack, c0_ack} = ack;
  assign p1        = pend[1] | pend[2];
  assign c0_ok     = pend[0] && (!p1 || c0_run < BURST);
  assign port_idle = (mem_ack == mem_req);
  assign busy      = (state == BUSY);
  assign done      = (state == BUSY) && port_idle;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // port_idle in IDLE also holds off grants while a pre-reset ack is still in flight
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = 2'd0;
    case (state)
      IDLE: begin
        if ((|pend) && port_idle) begin
          grant     = 1'b1;
          state_nxt = BUSY;
          if (c0_ok)                        win = 2'd0;
          else if (rr ? pend[2] : pend[1])  win = rr ? 2'd2 : 2'd1;
          else                              win = rr ? 2'd1 : 2'd2;
        end
      end
      BUSY: begin
        if (port_idle) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_req = c0_req; sel_we = c0_we; sel_a = c0_a; sel_ds = c0_ds; sel_d = c0_d;
    case (win)
      2'd1: begin sel_req = c1_req; sel_we = c1_we; sel_a = c1_a; sel_ds = c1_ds; sel_d = c1_d; end
      2'd2: begin sel_req = c2_req; sel_we = c2_we; sel_a = c2_a; sel_ds = c2_ds; sel_d = c2_d; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_a   <= '0;
      mem_ds  <= 2'b00;
      mem_d   <= 16'h0000;
      ack     <= 3'b000;
      c0_q    <= 16'h0000;
      c1_q    <= 16'h0000;
      c2_q    <= 16'h0000;
      c0_run  <= 4'd0;
      rr      <= 1'b0;
      gnt     <= 2'd3;
      gnt_req <= 1'b0;
    end else begin
      if (grant) begin
        mem_we  <= sel_we;
        mem_a   <= sel_a;
        mem_ds  <= sel_ds;
        mem_d   <= sel_d;
        mem_req <= ~mem_req;
        gnt     <= win;
        gnt_req <= sel_req;
        if (win == 2'd0) begin
          if (!p1)                 c0_run <= 4'd1;
          else if (c0_run < BURST) c0_run <= c0_run + 4'd1;
        end else begin
          c0_run <= 4'd0;
          rr     <= (win == 2'd1);
        end
      end
      // ack echoes the grant-time req so a client that re-toggled early stays pending
      if (done) begin
        case (gnt)
          2'd0: begin ack[0] <= gnt_req; if (!mem_we) c0_q <= mem_q; end
          2'd1: begin ack[1] <= gnt_req; if (!mem_we) c1_q <= mem_q; end
          2'd2: begin ack[2] <= gnt_req; if (!mem_we) c2_q <= mem_q; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb with a behavioural SDRAM port model and a
// queue of expected port transactions checked as each transfer starts.
module tb_sdram_port_arb;
  localparam int AW = 23;

  logic clk = 1'b0;
  logic init_n = 1'b1;
  always #5 clk = ~clk;

  logic c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0, c2_req = 0, c2_we = 0;
  logic [AW:1] c0_a = '0, c1_a = '0, c2_a = '0;
  logic [1:0]  c0_ds = '0, c1_ds = '0, c2_ds = '0;
  logic [15:0] c0_d = '0, c1_d = '0, c2_d = '0;
  logic c0_ack, c1_ack, c2_ack;
  logic [15:0] c0_q, c1_q, c2_q;
  logic mem_req, mem_we, busy;
  logic mem_ack = 1'b0;
  logic [15:0] mem_q = 16'h0000;
  logic [AW:1] mem_a;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;
  logic [2:0]  acks;
  assign acks = {c2_ack, c1_ack, c0_ack};

  sdram_port_arb #(.AW(AW), .C0_BURST(4)) dut (
    .clk(clk), .init_n(init_n),
    .c0_req(c0_req), .c0_ack(c0_ack), .c0_we(c0_we), .c0_a(c0_a), .c0_ds(c0_ds), .c0_d(c0_d), .c0_q(c0_q),
    .c1_req(c1_req), .c1_ack(c1_ack), .c1_we(c1_we), .c1_a(c1_a), .c1_ds(c1_ds), .c1_d(c1_d), .c1_q(c1_q),
    .c2_req(c2_req), .c2_ack(c2_ack), .c2_we(c2_we), .c2_a(c2_a), .c2_ds(c2_ds), .c2_d(c2_d), .c2_q(c2_q),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_d(mem_d), .mem_q(mem_q), .busy(busy)
  );

  typedef struct packed {
    logic        we;
    logic [AW:1] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } xfer_t;

  int          chk_n = 0;
  int          err_n = 0;
  xfer_t       exp_q[$];
  logic [15:0] mem [int unsigned];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk_n++;
    assert (obs === expv) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // SDRAM port model: fixed latency, ack echoes the req value seen at start
  int          lat = 8;
  int          m_cnt = 0;
  bit          m_busy = 0;
  logic        m_tag = 1'b0;
  xfer_t       m_x, m_e;
  logic [15:0] m_old;
  bit          force_en = 0;
  logic        force_val = 1'b0;

  always @(negedge clk) begin
    if (force_en) begin
      mem_ack = force_val;
      m_busy  = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (m_x.we) begin
          m_old = mem.exists(32'(m_x.a)) ? mem[32'(m_x.a)] : 16'h0000;
          if (m_x.ds[0]) m_old[7:0]  = m_x.d[7:0];
          if (m_x.ds[1]) m_old[15:8] = m_x.d[15:8];
          mem[32'(m_x.a)] = m_old;
        end else begin
          mem_q = mem.exists(32'(m_x.a)) ? mem[32'(m_x.a)] : 16'h0000;
        end
        mem_ack = m_tag;
        m_busy  = 0;
      end
    end else if (mem_req !== mem_ack) begin
      m_busy = 1;
      m_cnt  = lat;
      m_tag  = mem_req;
      m_x    = xfer_t'({mem_we, mem_a, mem_ds, mem_d});
      if (exp_q.size() == 0) begin
        check("sb_unexpected_xfer", 64'(m_x), 64'(0));
      end else begin
        m_e = exp_q.pop_front();
        check("sb_xfer", 64'(m_x), 64'(m_e));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [AW:1] addr_of(input int c);
    return (c == 0) ? 23'h000100 : (c == 1) ? 23'h000200 : 23'h000400;
  endfunction

  function automatic logic [15:0] data_of(input int c);
    return (c == 0) ? 16'h1111 : (c == 1) ? 16'h2222 : 16'h4444;
  endfunction

  function automatic logic [15:0] q_of(input int c);
    return (c == 0) ? c0_q : (c == 1) ? c1_q : c2_q;
  endfunction

  task automatic issue(input int c, input logic we, input logic [AW:1] a, input logic [1:0] ds,
                       input logic [15:0] d, input bit push);
    case (c)
      0: begin c0_we = we; c0_a = a; c0_ds = ds; c0_d = d; c0_req = ~c0_req; end
      1: begin c1_we = we; c1_a = a; c1_ds = ds; c1_d = d; c1_req = ~c1_req; end
      default: begin c2_we = we; c2_a = a; c2_ds = ds; c2_d = d; c2_req = ~c2_req; end
    endcase
    if (push) exp_q.push_back(xfer_t'({we, a, ds, d}));
  endtask

  function automatic xfer_t rd_of(input int c);
    return xfer_t'({1'b0, addr_of(c), 2'b11, 16'h0000});
  endfunction

  task automatic read_client(input int c, input bit push);
    issue(c, 1'b0, addr_of(c), 2'b11, 16'h0000, push);
  endtask

  // controller is reset alongside, so its ack returns to 0
  task automatic do_reset();
    force_en = 1; force_val = 1'b0;
    init_n = 1'b0;
    c0_req = 0; c1_req = 0; c2_req = 0;
    tick(); tick();
    init_n = 1'b1; force_en = 0;
    tick();
  endtask

  task automatic wait_any(output int who);
    logic [2:0] prev;
    int n;
    prev = acks;
    n = 0;
    while (acks === prev && n < 200) begin tick(); n++; end
    check("completion_timeout", 64'(n < 200), 64'(1));
    who = (acks[0] !== prev[0]) ? 0 : (acks[1] !== prev[1]) ? 1 : 2;
  endtask

  task automatic wait_ack(input int c, input string tag);
    int n;
    logic [2:0] reqv;
    n = 0;
    reqv = {c2_req, c1_req, c0_req};
    while (acks[c] !== reqv[c] && n < 300) begin
      tick(); n++;
      reqv = {c2_req, c1_req, c0_req};
    end
    check(tag, 64'(n < 300), 64'(1));
  endtask

  initial begin
    int who, n;
    bit ok;
    int ord_b[10];
    int ord_r[4];
    int ord_a[3];
    ord_b = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    ord_r = '{1, 2, 1, 2};
    ord_a = '{0, 1, 2};
    mem[32'h012345] = 16'hBEEF;
    mem[32'h000100] = 16'h1111;
    mem[32'h000200] = 16'h2222;
    mem[32'h000400] = 16'h4444;

    #1 init_n = 1'b0;
    tick(); tick();
    check("rst_acks", 64'(acks), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_out", 64'({mem_we, mem_a, mem_ds, mem_d}), 64'(0));
    check("rst_q", 64'({c0_q, c1_q, c2_q}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    init_n = 1'b1;
    tick();

    // single read from client 1
    issue(1, 1'b0, 23'h012345, 2'b11, 16'h0000, 1);
    tick();
    check("rd_mem_req", 64'(mem_req), 64'(1));
    check("rd_mem_a", 64'(mem_a), 64'(23'h012345));
    check("rd_busy", 64'(busy), 64'(1));
    n = 0;
    while (mem_ack !== mem_req && n < 50) begin tick(); n++; end
    check("rd_mem_ack_timeout", 64'(n < 50), 64'(1));
    check("rd_lat_clks", 64'(n), 64'(8));
    check("rd_ack_before", 64'(c1_ack), 64'(0));
    tick();
    check("rd_ack", 64'(c1_ack), 64'(1));
    check("rd_q", 64'(c1_q), 64'(16'hBEEF));
    check("rd_busy_low", 64'(busy), 64'(0));

    // write from client 2; inputs changed mid-transfer must not reach the port
    issue(2, 1'b1, 23'h7FFFFF, 2'b01, 16'h00A5, 1);
    tick();
    check("wr_mem_we", 64'(mem_we), 64'(1));
    check("wr_mem_ds", 64'(mem_ds), 64'(2'b01));
    check("wr_mem_d", 64'(mem_d), 64'(16'h00A5));
    c2_a = 23'h000555; c2_d = 16'h5A5A; c2_we = 1'b0; c2_ds = 2'b10;
    tick(); tick(); tick();
    check("wr_hold", 64'({mem_we, mem_a, mem_ds, mem_d}), 64'({1'b1, 23'h7FFFFF, 2'b01, 16'h00A5}));
    wait_ack(2, "wr_ack_timeout");
    check("wr_ack", 64'(c2_ack), 64'(1));
    check("wr_q_unchanged", 64'(c2_q), 64'(0));

    // client 0 burst limit against a continuously pending client 1
    lat = 3;
    do_reset();
    foreach (ord_b[k]) exp_q.push_back(rd_of(ord_b[k]));
    read_client(0, 0);
    read_client(1, 0);
    for (int k = 0; k < 10; k++) begin
      wait_any(who);
      check($sformatf("burst_order_%0d", k), 64'(who), 64'(ord_b[k]));
      check("burst_q", 64'(q_of(who)), 64'(data_of(who)));
      if (k < 8) read_client(who, 0);
    end

    // round robin between clients 1 and 2
    do_reset();
    foreach (ord_r[k]) exp_q.push_back(rd_of(ord_r[k]));
    read_client(1, 0);
    read_client(2, 0);
    for (int k = 0; k < 4; k++) begin
      wait_any(who);
      check($sformatf("rr_order_%0d", k), 64'(who), 64'(ord_r[k]));
      if (k < 2) read_client(who, 0);
    end

    // all three pending: client 0 first, then rr continues at client 1
    foreach (ord_a[k]) exp_q.push_back(rd_of(ord_a[k]));
    read_client(0, 0);
    read_client(1, 0);
    read_client(2, 0);
    for (int k = 0; k < 3; k++) begin
      wait_any(who);
      check($sformatf("all3_order_%0d", k), 64'(who), 64'(ord_a[k]));
    end

    // reset in the middle of a transfer whose ack arrives after reset release
    do_reset();
    read_client(0, 1);
    wait_ack(0, "pre_ack_timeout");
    lat = 30;
    read_client(1, 1);
    tick(); tick(); tick();
    check("mid_busy", 64'(busy), 64'(1));
    check("mid_mem_req", 64'(mem_req), 64'(0));
    init_n = 1'b0;
    c0_req = 1'b0;
    #1;
    check("mid_rst_acks", 64'(acks), 64'(0));
    check("mid_rst_out", 64'({busy, mem_req, mem_a}), 64'(0));
    tick();
    init_n = 1'b1;
    exp_q.push_back(rd_of(1));
    ok = 1; n = 0;
    while (mem_ack !== mem_req && n < 100) begin
      if (mem_req !== 1'b0 || busy !== 1'b0) ok = 0;
      tick(); n++;
    end
    check("stale_wait_seen", 64'(n > 5 && n < 100), 64'(1));
    check("no_grant_while_stale", 64'(ok), 64'(1));
    wait_ack(1, "reserve_timeout");
    check("reserve_q", 64'(c1_q), 64'(16'h2222));

    // controller ack stuck high after reset blocks the first grant
    lat = 3;
    force_en = 1; force_val = 1'b1;
    init_n = 1'b0;
    c0_req = 0; c1_req = 0; c2_req = 0;
    tick(); tick();
    init_n = 1'b1;
    read_client(0, 1);
    ok = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_req !== 1'b0 || busy !== 1'b0) ok = 0;
    end
    check("guard_no_toggle", 64'(ok), 64'(1));
    check("guard_no_ack", 64'(c0_ack), 64'(0));
    force_val = 1'b0;
    tick();
    force_en = 0;
    wait_ack(0, "guard_ack_timeout");
    check("guard_q", 64'(c0_q), 64'(16'h1111));

    tick(); tick();
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", err_n, chk_n);
    $finish;
  end

endmodule
